wb_port_arbiter: RTL

Writeback arbiter for the 4W/8R, 32 x 16b physical register file. It collects results from NUM_REQ execution/load requesters that compete for the NUM_WR register-file write ports. Each cycle it grants up to NUM_WR requests in round-robin order and suppresses same-register collisions. Granted writes are presented to the register file write ports through one pipeline register.

---
 rtl/rf_pkg.sv | 15 +
 rtl/wb_port_arbiter_rr_mask_picker.sv | 31 +++
 rtl/wb_port_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared register-file definitions used by the writeback arbiter and by rename/issue.
// Default port/width constants plus the request payload type.
package rf_pkg;

    localparam int NUM_WR  = 4;
    localparam int PREG_W  = 5;
    localparam int DATA_W  = 16;
    localparam int STALL_W = 16;

    typedef struct packed {
        logic [PREG_W-1:0] preg;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_rr_mask_picker.sv
// Rotated find-first-set: returns the first set bit of elig at or after ptr, wrapping mod N.
module rr_mask_picker #(
    parameter int N     = 6,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     elig,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [PTR_W-1:0] idx
);

    logic [PTR_W:0] pos;

    // Walk the scan order backwards so the earliest eligible position wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (pos >= (PTR_W + 1)'(N)) begin
                pos = pos - (PTR_W + 1)'(N);
            end
            if (elig[pos[PTR_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: round-robin grant of up to NUM_WR requesters per cycle onto the
// register-file write ports, with same-preg collision suppression and one output register.
module wb_port_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ = 6,
    parameter int NUM_WR  = rf_pkg::NUM_WR,
    parameter int PREG_W  = rf_pkg::PREG_W,
    parameter int DATA_W  = rf_pkg::DATA_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][PREG_W-1:0]   req_preg,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_WR-1:0]                reg_wr_en,
    output logic [NUM_WR-1:0][PREG_W-1:0]    reg_wr_addr,
    output logic [NUM_WR-1:0][DATA_W-1:0]    reg_wr_data,
    output logic [STALL_W-1:0]               stall_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (&v) ? v : v + STALL_W'(1);
    endfunction

    logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [STALL_W-1:0]               stall_cnt_q, stall_cnt_d;
    logic [NUM_WR-1:0]                wr_en_q, wr_en_d;
    logic [NUM_WR-1:0][PREG_W-1:0]    wr_addr_q, wr_addr_d;
    logic [NUM_WR-1:0][DATA_W-1:0]    wr_data_q, wr_data_d;

    logic [NUM_WR-1:0]                grant_vld;
    logic [NUM_WR-1:0][PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]                 last_idx;
    logic                             any_grant;

    // Stage k excludes everything granted by earlier stages and every requester whose
    // preg matches one of those grants; the granted requester matches itself.
    for (genvar g = 0; g < NUM_WR; g++) begin : g_stage
        logic [NUM_REQ-1:0] excl_in;
        logic [NUM_REQ-1:0] excl_out;
        logic [NUM_REQ-1:0] elig;
        logic               found;
        logic [PTR_W-1:0]   idx;

        if (g == 0) begin : g_first
            assign excl_in = '0;
        end else begin : g_next
            assign excl_in = g_stage[g-1].excl_out;
        end

        assign elig = req_valid & ~excl_in & {NUM_REQ{~rst}};

        rr_mask_picker #(
            .N     (NUM_REQ),
            .PTR_W (PTR_W)
        ) u_pick (
            .elig  (elig),
            .ptr   (rr_ptr_q),
            .found (found),
            .idx   (idx)
        );

        always_comb begin
            excl_out = excl_in;
            if (found) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_preg[i] == req_preg[idx]) begin
                        excl_out[i] = 1'b1;
                    end
                end
            end
        end

        assign grant_vld[g] = found;
        assign grant_idx[g] = idx;
    end

    // Grants form a contiguous prefix of stages, so stage k maps directly to port k.
    always_comb begin
        req_ready   = '0;
        wr_en_d     = '0;
        wr_addr_d   = '0;
        wr_data_d   = '0;
        last_idx    = rr_ptr_q;
        any_grant   = 1'b0;
        for (int g = 0; g < NUM_WR; g++) begin
            if (grant_vld[g]) begin
                req_ready[grant_idx[g]] = 1'b1;
                wr_en_d[g]              = 1'b1;
                wr_addr_d[g]            = req_preg[grant_idx[g]];
                wr_data_d[g]            = req_data[grant_idx[g]];
                last_idx                = grant_idx[g];
                any_grant               = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_grant) begin
            rr_ptr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
        end
        stall_cnt_d = stall_cnt_q;
        if (|(req_valid & ~req_ready)) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    // Reset clears the output stage too: a pending write is discarded with the backend flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            stall_cnt_q <= '0;
            wr_en_q     <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            stall_cnt_q <= stall_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign reg_wr_en   = wr_en_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
